// File: rtl/clock_mode_ctrl_if.sv
// Button, time/alarm and control signals between the alarm-clock front end and the mode sequencer.
// master drives buttons and time values; slave (the sequencer) drives the mode/buzzer outputs.
interface clock_mode_ctrl_if;
  logic       btn_c;
  logic       btn_l;
  logic       btn_r;
  logic [1:0] th1;
  logic [3:0] th2;
  logic [2:0] tm1;
  logic [3:0] tm2;
  logic [1:0] ah1;
  logic [3:0] ah2;
  logic [2:0] am1;
  logic [3:0] am2;
  logic       adjust;
  logic       enth;
  logic       entm;
  logic       enah;
  logic       enam;
  logic       ens;
  logic       armed;
  logic       buzzer;

  modport master (
    output btn_c, btn_l, btn_r, th1, th2, tm1, tm2, ah1, ah2, am1, am2,
    input  adjust, enth, entm, enah, enam, ens, armed, buzzer
  );

  modport slave (
    input  btn_c, btn_l, btn_r, th1, th2, tm1, tm2, ah1, ah2, am1, am2,
    output adjust, enth, entm, enah, enam, ens, armed, buzzer
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Alarm-clock mode sequencer: button-driven adjust field selection, alarm arming,
// and a timed blinking buzzer triggered when the time rolls into equality with the alarm.
module clock_mode_ctrl #(
  parameter int RING_TIMEOUT = 12000,
  parameter int BLINK_HALF   = 100
) (
  input  logic             clk,
  input  logic             rst,
  clock_mode_ctrl_if.slave bus
);

  localparam int RING_W  = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [2:0] {
    CLOCK  = 3'd0,
    ADJ_TH = 3'd1,
    ADJ_TM = 3'd2,
    ADJ_AH = 3'd3,
    ADJ_AM = 3'd4,
    RING   = 3'd5
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic                 armed_reg;
  logic                 buzzer_reg;
  logic                 match_q_reg;
  logic [RING_W-1:0]    ring_cnt_reg;
  logic [BLINK_W-1:0]   blink_cnt_reg;

  logic any_btn;
  logic match;
  logic ring_last;
  logic blink_last;
  logic armed_toggle;

  assign any_btn    = bus.btn_c | bus.btn_l | bus.btn_r;
  assign match      = ({bus.th1, bus.th2, bus.tm1, bus.tm2} == {bus.ah1, bus.ah2, bus.am1, bus.am2});
  assign ring_last  = (ring_cnt_reg == RING_W'(RING_TIMEOUT - 1));
  assign blink_last = (blink_cnt_reg == BLINK_W'(BLINK_HALF - 1));
  // btn_r outranks btn_l, so a simultaneous right press swallows the arm toggle.
  assign armed_toggle = (state_reg == CLOCK) && !bus.btn_c && !bus.btn_r && bus.btn_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CLOCK;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLOCK: begin
        if (bus.btn_c) begin
          state_next = ADJ_TH;
        end else if (!any_btn && armed_reg && match && !match_q_reg) begin
          state_next = RING;
        end
      end
      ADJ_TH: begin
        if (bus.btn_c)      state_next = CLOCK;
        else if (bus.btn_r) state_next = ADJ_TM;
        else if (bus.btn_l) state_next = ADJ_AM;
      end
      ADJ_TM: begin
        if (bus.btn_c)      state_next = CLOCK;
        else if (bus.btn_r) state_next = ADJ_AH;
        else if (bus.btn_l) state_next = ADJ_TH;
      end
      ADJ_AH: begin
        if (bus.btn_c)      state_next = CLOCK;
        else if (bus.btn_r) state_next = ADJ_AM;
        else if (bus.btn_l) state_next = ADJ_TM;
      end
      ADJ_AM: begin
        if (bus.btn_c)      state_next = CLOCK;
        else if (bus.btn_r) state_next = ADJ_TH;
        else if (bus.btn_l) state_next = ADJ_AH;
      end
      RING: begin
        if (any_btn || ring_last) state_next = CLOCK;
      end
      default: state_next = CLOCK;
    endcase
  end

  // match_q resets to 1 so an equal time/alarm at power-up is not seen as a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_reg     <= 1'b0;
      buzzer_reg    <= 1'b0;
      match_q_reg   <= 1'b1;
      ring_cnt_reg  <= '0;
      blink_cnt_reg <= '0;
    end else begin
      match_q_reg <= match;
      if (armed_toggle) begin
        armed_reg <= ~armed_reg;
      end
      if (state_next == RING) begin
        if (state_reg != RING) begin
          ring_cnt_reg  <= '0;
          blink_cnt_reg <= '0;
          buzzer_reg    <= 1'b1;
        end else begin
          ring_cnt_reg <= ring_cnt_reg + RING_W'(1);
          if (blink_last) begin
            blink_cnt_reg <= '0;
            buzzer_reg    <= ~buzzer_reg;
          end else begin
            blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
          end
        end
      end else begin
        ring_cnt_reg  <= '0;
        blink_cnt_reg <= '0;
        buzzer_reg    <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.adjust = 1'b0;
    bus.enth   = 1'b0;
    bus.entm   = 1'b0;
    bus.enah   = 1'b0;
    bus.enam   = 1'b0;
    bus.ens    = 1'b1;
    case (state_reg)
      ADJ_TH: begin bus.adjust = 1'b1; bus.ens = 1'b0; bus.enth = 1'b1; end
      ADJ_TM: begin bus.adjust = 1'b1; bus.ens = 1'b0; bus.entm = 1'b1; end
      ADJ_AH: begin bus.adjust = 1'b1; bus.ens = 1'b0; bus.enah = 1'b1; end
      ADJ_AM: begin bus.adjust = 1'b1; bus.ens = 1'b0; bus.enam = 1'b1; end
      default: ;
    endcase
  end

  assign bus.armed  = armed_reg;
  assign bus.buzzer = buzzer_reg;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: driver steps a mode-level reference model and queues
// the expected outputs; a negedge monitor pops and compares them against the DUT.
module tb_clock_mode_ctrl;

  localparam int RT = 12000;
  localparam int BH = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_mode_ctrl_if bus();

  clock_mode_ctrl #(
    .RING_TIMEOUT(RT),
    .BLINK_HALF  (BH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];

  // Reference model: mode 0=clock, 1=adjusting field m_field (0..3 = TH,TM,AH,AM), 2=ringing.
  int m_mode;
  int m_field;
  int m_elapsed;
  bit m_armed;
  bit m_last_match;
  int t_h, t_m, a_h, a_m;

  task automatic model_reset();
    m_mode       = 0;
    m_field      = 0;
    m_elapsed    = 0;
    m_armed      = 1'b0;
    m_last_match = 1'b1;
  endtask

  // Output order: {adjust, enth, entm, enah, enam, ens, armed, buzzer}
  function automatic logic [7:0] model_out();
    logic       adj;
    logic [3:0] en;
    logic       buz;
    adj = (m_mode == 1);
    en  = adj ? (4'b1000 >> m_field) : 4'b0000;
    buz = (m_mode == 2) && (((m_elapsed / BH) % 2) == 0);
    return {adj, en, ~adj, m_armed, buz};
  endfunction

  task automatic model_step(input bit c, input bit l, input bit r);
    bit m;
    m = (t_h == a_h) && (t_m == a_m);
    case (m_mode)
      0: begin
        if (c) begin
          m_mode  = 1;
          m_field = 0;
        end else if (r) begin
        end else if (l) begin
          m_armed = !m_armed;
        end else if (m_armed && m && !m_last_match) begin
          m_mode    = 2;
          m_elapsed = 0;
        end
      end
      1: begin
        if (c)      m_mode  = 0;
        else if (r) m_field = (m_field + 1) % 4;
        else if (l) m_field = (m_field + 3) % 4;
      end
      default: begin
        if (c || l || r)          m_mode = 0;
        else if (m_elapsed == RT - 1) m_mode = 0;
        else                      m_elapsed++;
      end
    endcase
    m_last_match = m;
  endtask

  task automatic drive_values();
    bus.th1 = 2'(t_h / 10);
    bus.th2 = 4'(t_h % 10);
    bus.tm1 = 3'(t_m / 10);
    bus.tm2 = 4'(t_m % 10);
    bus.ah1 = 2'(a_h / 10);
    bus.ah2 = 4'(a_h % 10);
    bus.am1 = 3'(a_m / 10);
    bus.am2 = 4'(a_m % 10);
  endtask

  task automatic cycle(input bit c = 1'b0, input bit l = 1'b0, input bit r = 1'b0);
    @(negedge clk);
    #1;
    bus.btn_c = c;
    bus.btn_l = l;
    bus.btn_r = r;
    drive_values();
    model_step(c, l, r);
    exp_q.push_back(model_out());
    cyc++;
    if (c || l || r)
      $display("cyc=%0d btn c=%0d l=%0d r=%0d time=%02d:%02d alarm=%02d:%02d", cyc, c, l, r, t_h, t_m, a_h, a_m);
  endtask

  function automatic logic [7:0] dut_out();
    return {bus.adjust, bus.enth, bus.entm, bus.enah, bus.enam, bus.ens, bus.armed, bus.buzzer};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", dut_out(), e);
    end
  end

  task automatic ring_setup();
    t_h = 6; t_m = 59;
    repeat (3) cycle();
    t_h = 7; t_m = 0;
  endtask

  initial begin
    int p;
    bus.btn_c = 1'b0;
    bus.btn_l = 1'b0;
    bus.btn_r = 1'b0;
    t_h = 12; t_m = 34; a_h = 12; a_m = 34;
    drive_values();
    model_reset();

    // Reset with time == alarm
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", dut_out(), model_out());
    rst = 1'b0;
    $display("phase reset released, time=alarm=12:34");
    repeat (5) cycle();
    cycle(1'b0, 1'b1, 1'b0);
    repeat (5) cycle();

    // Adjust field walk
    $display("phase adjust walk");
    cycle(1'b1); cycle();
    repeat (4) begin cycle(1'b0, 1'b0, 1'b1); cycle(); end
    cycle(1'b0, 1'b1, 1'b0); cycle();
    cycle(1'b1); cycle();

    // Full ring to timeout, then no re-ring while time stays equal
    $display("phase ring timeout");
    a_h = 7; a_m = 0;
    ring_setup();
    repeat (RT + 10) cycle();

    // Dismiss with btn_r after 50 cycles
    $display("phase ring dismiss");
    ring_setup();
    repeat (51) cycle();
    cycle(1'b0, 1'b0, 1'b1);
    repeat (10) cycle();

    // Simultaneous buttons in CLOCK
    $display("phase simultaneous buttons");
    cycle(1'b1, 1'b1, 1'b0); cycle();
    cycle(1'b1); cycle();
    cycle(1'b0, 1'b1, 1'b1); cycle();

    // Async reset during ring
    $display("phase reset mid-ring");
    ring_setup();
    repeat (301) cycle();
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_reset", dut_out(), model_out());
    @(negedge clk);
    check("reset_hold", dut_out(), model_out());
    rst = 1'b0;
    repeat (5) cycle();

    // Randomized traffic
    $display("phase random");
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) begin
        a_h = $urandom_range(0, 23);
        a_m = $urandom_range(0, 59);
      end
      if ($urandom_range(0, 14) == 0) begin
        t_h = a_h;
        t_m = ($urandom_range(0, 1) == 1) ? a_m : int'($urandom_range(0, 59));
      end
      p = $urandom_range(0, 39);
      cycle(p == 0 || p == 4, p == 1 || p == 3, p == 2 || p == 3 || p == 4);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
